conv_window_accumulator: RTL and testbench
==========================================

# conv_window_accumulator

Sink-side partner of the kernel tap counter: it consumes the 0..8 kernel-index stream together with one pixel and one weight per tap. It multiplies and accumulates the 9 products of each 3x3 window and emits one convolution result per window. A run covers the 4 windows of a 4x4 image, giving a 2x2 output. It sits between the tap sequencer/operand fetch and the output-pixel store.

## Interface
- DATA_W, 4: pixel and weight width (unsigned)
- TAPS, 9: taps per window; valid kernel indices are 0..TAPS-1
- WINDOWS, 4: windows per run
- ACC_W, 12: accumulator/result width; 9*15*15 = 2025 fits with no overflow

- CLK  in  1  clock; all state updates on the rising edge
- RESET  in  1  synchronous, active-high reset
- START  in  1  begin a run; sampled only in IDLE
- IN_VALID  in  1  K_IDX/PIXEL/WEIGHT valid this cycle
- K_IDX  in  4  kernel tap index from the tap counter
- PIXEL  in  DATA_W  image pixel for this tap
- WEIGHT  in  DATA_W  kernel weight for this tap
- OUT_VALID  out  1  one-cycle pulse: OUT_DATA/OUT_WIN valid
- OUT_DATA  out  ACC_W  window sum; holds its value between pulses
- OUT_WIN  out  2  window number 0..3 of OUT_DATA (row-major)
- BUSY  out  1  high in ACCUM
- DONE  out  1  one-cycle pulse with the last window's OUT_VALID
- SEQ_ERR  out  1  sticky: an out-of-order tap index was seen

## Operation
- States: IDLE, ACCUM.
- Reset: state=IDLE; acc=0, exp_idx=0, win=0. OUT_VALID=0, OUT_DATA=0, OUT_WIN=0, BUSY=0, DONE=0, SEQ_ERR=0.
- IDLE, START=1: clear acc, exp_idx, win and SEQ_ERR; go to ACCUM. START in ACCUM is ignored.
- IDLE: IN_VALID is ignored.
- ACCUM, IN_VALID=0: hold all state.
- ACCUM, IN_VALID=1 and K_IDX==exp_idx, exp_idx<8: acc += PIXEL*WEIGHT (unsigned, zero-extended to ACC_W); exp_idx++.
- ACCUM, IN_VALID=1 and K_IDX==exp_idx==8 (window close):
  - OUT_DATA <= acc+PIXEL*WEIGHT, OUT_WIN <= win, OUT_VALID <= 1.
  - acc <= 0, exp_idx <= 0.
  - If win==WINDOWS-1: DONE <= 1 and go to IDLE. Otherwise win++.
- ACCUM, IN_VALID=1 and K_IDX!=exp_idx (includes K_IDX>8):
  - SEQ_ERR <= 1; the sample is dropped.
  - acc <= 0, exp_idx <= 0, so the current window restarts; win is unchanged.
  - If this sample has K_IDX==0, it is not re-evaluated; the next accepted tap 0 starts the window.
- Arithmetic: the product is 2*DATA_W bits. No saturation or overflow checks are needed at the defaults.

## Timing
- Accepting a tap takes 1 cycle; the block never stalls its source, so there is no back-pressure.
- OUT_VALID and DONE are registered: asserted the cycle after tap 8 is accepted, high for exactly 1 cycle.
- Back-to-back windows are supported: tap 0 of window n+1 may be presented in the cycle OUT_VALID for window n is high.
- BUSY falls in the same cycle DONE rises.
- A new START is accepted when presented in the DONE cycle or later.
- Minimum run length: 36 accepted taps plus 1 cycle, i.e. DONE 37 cycles after the first tap with continuous IN_VALID.
- RESET mid-run takes priority over all inputs.
  - Next cycle: reset state, with no OUT_VALID or DONE for the partial window.
- Gaps in IN_VALID of any length are allowed in ACCUM.
  - They change no state and extend latency 1:1.

## Test plan
- Continuous run, PIXEL=15 and WEIGHT=15 on every tap: OUT_DATA=2025 four times with OUT_WIN=0,1,2,3, and DONE together with the 4th OUT_VALID, 37 cycles after the first tap.
- PIXEL=1..9 for taps 0..8, WEIGHT=1, one window with random IN_VALID gaps: OUT_DATA=45 with OUT_WIN=0, exactly one OUT_VALID, and BUSY still 1.
- Indices 0,1,3: SEQ_ERR=1 and acc cleared. Then a clean 0..8 with PIXEL=2, WEIGHT=3 gives OUT_DATA=54 with OUT_WIN=0, and SEQ_ERR stays 1 until the next START.
- RESET asserted after tap 5 of window 2: next cycle all outputs are 0 and the state is IDLE. No OUT_VALID appears, and later taps are ignored until START.
- START pulsed mid-run, then again in the DONE cycle: the first has no effect on win or acc; the second starts a new run with win=0 and SEQ_ERR cleared.
- K_IDX=9 presented as the first tap, with IN_VALID=1: SEQ_ERR=1, no accumulation, and exp_idx stays 0.

Source files
------------

// File: rtl/conv_window_accumulator_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// conv_window_accumulator_if : tap stream in, window results out
// Revision 1.0
// ----------------------------------------------------------------------------
interface conv_window_accumulator_if #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 12,
    parameter int WIN_W  = 2
);
    logic              start;
    logic              in_valid;
    logic [3:0]        k_idx;
    logic [DATA_W-1:0] pixel;
    logic [DATA_W-1:0] weight;
    logic              out_valid;
    logic [ACC_W-1:0]  out_data;
    logic [WIN_W-1:0]  out_win;
    logic              busy;
    logic              done;
    logic              seq_err;

    modport master (
        output start, in_valid, k_idx, pixel, weight,
        input  out_valid, out_data, out_win, busy, done, seq_err
    );

    modport slave (
        input  start, in_valid, k_idx, pixel, weight,
        output out_valid, out_data, out_win, busy, done, seq_err
    );
endinterface
`default_nettype wire

// File: rtl/conv_window_accumulator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// conv_window_accumulator : MAC of 9 taps per 3x3 window, 4 windows per run
// Revision 1.0
// ----------------------------------------------------------------------------
module conv_window_accumulator #(
    parameter int DATA_W  = 4,
    parameter int TAPS    = 9,
    parameter int WINDOWS = 4,
    parameter int ACC_W   = 12
) (
    input  wire                          clk_i,
    input  wire                          rst_i,
    conv_window_accumulator_if.slave     acc_if
);
    localparam int WIN_W = (WINDOWS > 1) ? $clog2(WINDOWS) : 1;
    localparam logic [3:0]       LAST_TAP = 4'(TAPS - 1);
    localparam logic [WIN_W-1:0] LAST_WIN = WIN_W'(WINDOWS - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [3:0]         exp_idx_q, exp_idx_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;
    logic [WIN_W-1:0]   out_win_q, out_win_d;
    logic               out_valid_q, out_valid_d;
    logic               done_q, done_d;
    logic               seq_err_q, seq_err_d;

    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    prod_ext;

    assign prod     = acc_if.pixel * acc_if.weight;
    assign prod_ext = ACC_W'(prod);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            exp_idx_q   <= '0;
            win_q       <= '0;
            out_data_q  <= '0;
            out_win_q   <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            exp_idx_q   <= exp_idx_d;
            win_q       <= win_d;
            out_data_q  <= out_data_d;
            out_win_q   <= out_win_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            seq_err_q   <= seq_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        exp_idx_d   = exp_idx_q;
        win_d       = win_q;
        out_data_d  = out_data_q;
        out_win_d   = out_win_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        seq_err_d   = seq_err_q;

        case (state_q)
            IDLE: begin
                if (acc_if.start) begin
                    acc_d     = '0;
                    exp_idx_d = '0;
                    win_d     = '0;
                    seq_err_d = 1'b0;
                    state_d   = ACCUM;
                end
            end
            ACCUM: begin
                if (acc_if.in_valid) begin
                    // An out-of-order tap drops the sample and restarts the window.
                    if (acc_if.k_idx != exp_idx_q) begin
                        seq_err_d = 1'b1;
                        acc_d     = '0;
                        exp_idx_d = '0;
                    end else if (exp_idx_q == LAST_TAP) begin
                        out_data_d  = acc_q + prod_ext;
                        out_win_d   = win_q;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        exp_idx_d   = '0;
                        if (win_q == LAST_WIN) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            win_d = win_q + WIN_W'(1);
                        end
                    end else begin
                        acc_d     = acc_q + prod_ext;
                        exp_idx_d = exp_idx_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign acc_if.out_valid = out_valid_q;
    assign acc_if.out_data  = out_data_q;
    assign acc_if.out_win   = out_win_q;
    assign acc_if.busy      = (state_q == ACCUM);
    assign acc_if.done      = done_q;
    assign acc_if.seq_err   = seq_err_q;
endmodule
`default_nettype wire

// File: tb/tb_conv_window_accumulator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_conv_window_accumulator : vector table, directed sequences, random vs model
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_conv_window_accumulator;
    localparam int DATA_W  = 4;
    localparam int TAPS    = 9;
    localparam int WINDOWS = 4;
    localparam int ACC_W   = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_window_accumulator_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .WIN_W(2)) bus ();

    conv_window_accumulator #(
        .DATA_W(DATA_W), .TAPS(TAPS), .WINDOWS(WINDOWS), .ACC_W(ACC_W)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .acc_if(bus)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    string phase    = "init";

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s [%s]: got %0d, expected %0d", name, phase, act, exp);
        end
    endtask

    // Reference model: a window is the list of accepted products; it closes at TAPS entries.
    bit m_run;
    int m_q[$];
    int m_win, m_od, m_ow;
    bit m_ov, m_done, m_se;

    task automatic model_step(input bit r, input bit s, input bit v, input int k, input int p, input int w);
        int sum;
        m_ov   = 1'b0;
        m_done = 1'b0;
        if (r) begin
            m_run = 1'b0; m_q.delete(); m_win = 0; m_od = 0; m_ow = 0; m_se = 1'b0;
        end else if (!m_run) begin
            if (s) begin
                m_run = 1'b1; m_q.delete(); m_win = 0; m_se = 1'b0;
            end
        end else if (v) begin
            if (k == m_q.size()) begin
                m_q.push_back(p * w);
                if (m_q.size() == TAPS) begin
                    sum = 0;
                    foreach (m_q[i]) sum += m_q[i];
                    m_od = sum; m_ow = m_win; m_ov = 1'b1;
                    m_q.delete();
                    if (m_win == WINDOWS - 1) begin
                        m_done = 1'b1; m_run = 1'b0;
                    end else begin
                        m_win++;
                    end
                end
            end else begin
                m_se = 1'b1;
                m_q.delete();
            end
        end
    endtask

    task automatic cyc(input bit r, input bit s, input bit v, input int k, input int p, input int w);
        rst          = r;
        bus.start    = s;
        bus.in_valid = v;
        bus.k_idx    = 4'(k);
        bus.pixel    = 4'(p);
        bus.weight   = 4'(w);
        @(posedge clk);
        model_step(r, s, v, k, p, w);
        #1;
        chk("model_out_valid", 32'(bus.out_valid), int'(m_ov));
        chk("model_out_data",  32'(bus.out_data),  m_od);
        chk("model_out_win",   32'(bus.out_win),   m_ow);
        chk("model_busy",      32'(bus.busy),      int'(m_run));
        chk("model_done",      32'(bus.done),      int'(m_done));
        chk("model_seq_err",   32'(bus.seq_err),   int'(m_se));
    endtask

    task automatic do_reset(); cyc(1, 0, 0, 0, 0, 0); endtask
    task automatic do_start(); cyc(0, 1, 0, 0, 0, 0); endtask
    task automatic idle();     cyc(0, 0, 0, 0, 0, 0); endtask
    task automatic tap(input int k, input int p, input int w); cyc(0, 0, 1, k, p, w); endtask

    typedef struct {
        bit r, s, v;
        int k, p, w;
        bit ov;
        int od, ow;
        bit busy, done, se;
    } vec_t;
    vec_t tbl[$];

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        int pulses;
        int gaps;
        bit no_out;
        bit no_busy;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.k_idx = '0; bus.pixel = '0; bus.weight = '0;

        // Out-of-order indices 0,1,3 then a clean window of 2*3 products.
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 2, 3, 0, 0, 0, 1, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 2, 3, 0, 0, 0, 1, 0, 0});
        tbl.push_back('{0, 0, 1, 3, 2, 3, 0, 0, 0, 1, 0, 1});
        for (int i = 0; i < 8; i++)
            tbl.push_back('{0, 0, 1, i, 2, 3, 0, 0, 0, 1, 0, 1});
        tbl.push_back('{0, 0, 1, 8, 2, 3, 1, 54, 0, 1, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 54, 0, 1, 0, 1});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 54, 0, 1, 0, 1});
        // K_IDX=9 as first tap: nothing accumulated, window still expects tap 0.
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0});
        tbl.push_back('{0, 0, 1, 9, 5, 5, 0, 0, 0, 1, 0, 1});
        for (int i = 0; i < 8; i++)
            tbl.push_back('{0, 0, 1, i, 1, 1, 0, 0, 0, 1, 0, 1});
        tbl.push_back('{0, 0, 1, 8, 1, 1, 1, 9, 0, 1, 0, 1});

        phase = "table";
        foreach (tbl[n]) begin
            cyc(tbl[n].r, tbl[n].s, tbl[n].v, tbl[n].k, tbl[n].p, tbl[n].w);
            chk("tbl_out_valid", 32'(bus.out_valid), int'(tbl[n].ov));
            chk("tbl_out_data",  32'(bus.out_data),  tbl[n].od);
            chk("tbl_out_win",   32'(bus.out_win),   tbl[n].ow);
            chk("tbl_busy",      32'(bus.busy),      int'(tbl[n].busy));
            chk("tbl_done",      32'(bus.done),      int'(tbl[n].done));
            chk("tbl_seq_err",   32'(bus.seq_err),   int'(tbl[n].se));
        end

        // Continuous full-scale run: 2025 per window, DONE with the 4th result.
        phase = "full_scale";
        do_reset(); do_start();
        for (int t = 0; t < 36; t++) begin
            tap(t % 9, 15, 15);
            chk("fs_out_valid", 32'(bus.out_valid), int'((t % 9) == 8));
            chk("fs_done",      32'(bus.done),      int'(t == 35));
            chk("fs_busy",      32'(bus.busy),      int'(t != 35));
            if ((t % 9) == 8) begin
                chk("fs_out_data", 32'(bus.out_data), 2025);
                chk("fs_out_win",  32'(bus.out_win),  t / 9);
            end
        end

        // One window 1..9 with random IN_VALID gaps.
        phase = "gaps";
        do_reset(); do_start();
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            gaps = $urandom_range(0, 3);
            for (int g = 0; g < gaps; g++) begin
                cyc(0, 0, 0, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
                pulses += int'(bus.out_valid);
            end
            tap(i, i + 1, 1);
            pulses += int'(bus.out_valid);
        end
        chk("gap_out_data", 32'(bus.out_data), 45);
        chk("gap_out_win",  32'(bus.out_win),  0);
        chk("gap_busy",     32'(bus.busy),     1);
        for (int g = 0; g < 3; g++) begin
            idle();
            pulses += int'(bus.out_valid);
        end
        chk("gap_pulse_count", 32'(pulses), 1);

        // Reset after tap 5 of window 2, then taps without START are ignored.
        phase = "mid_reset";
        do_reset(); do_start();
        for (int t = 0; t < 18; t++) tap(t % 9, 3, 2);
        for (int i = 0; i <= 5; i++) tap(i, 3, 2);
        cyc(1, 1, 1, 6, 3, 2);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data",  32'(bus.out_data),  0);
        chk("rst_out_win",   32'(bus.out_win),   0);
        chk("rst_busy",      32'(bus.busy),      0);
        chk("rst_done",      32'(bus.done),      0);
        chk("rst_seq_err",   32'(bus.seq_err),   0);
        no_out = 1'b1; no_busy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tap(i, 3, 2);
            if (bus.out_valid !== 1'b0) no_out = 1'b0;
            if (bus.busy !== 1'b0) no_busy = 1'b0;
        end
        chk("rst_ignored_no_out", 32'(no_out), 1);
        chk("rst_ignored_idle",   32'(no_busy), 1);

        // START mid-run is ignored; START in the DONE cycle begins a fresh run.
        phase = "restart";
        do_reset(); do_start();
        for (int i = 0; i < 4; i++) tap(i, 2, 2);
        do_start();
        for (int i = 4; i < 9; i++) tap(i, 2, 2);
        chk("rs_w0_data", 32'(bus.out_data), 36);
        chk("rs_w0_win",  32'(bus.out_win),  0);
        tap(0, 1, 1); tap(2, 1, 1);
        chk("rs_seq_err", 32'(bus.seq_err), 1);
        for (int t = 0; t < 27; t++) tap(t % 9, 1, 1);
        chk("rs_w3_win",  32'(bus.out_win), 3);
        chk("rs_done",    32'(bus.done),    1);
        do_start();
        chk("rs_new_busy",    32'(bus.busy),    1);
        chk("rs_new_seq_err", 32'(bus.seq_err), 0);
        for (int i = 0; i < 9; i++) tap(i, 1, 2);
        chk("rs_new_data", 32'(bus.out_data), 18);
        chk("rs_new_win",  32'(bus.out_win),  0);

        // Random traffic against the model.
        phase = "random";
        do_reset(); do_start();
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 299) == 0),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 9) < 7),
                ($urandom_range(0, 19) != 0) ? m_q.size() : $urandom_range(0, 15),
                $urandom_range(0, 15),
                $urandom_range(0, 15));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
